// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy quarter/dime/nickel payout with per-coin inventory
module change_dispenser #(
  parameter int WIDTH      = 8,
  parameter int STOCK_W    = 6,
  parameter int INIT_STOCK = 10,
  parameter int MAX_STOCK  = 63
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   balance,
  output logic               eject_valid,
  output logic [2:0]         eject_coin,
  input  logic               eject_ack,
  input  logic               refill,
  input  logic [2:0]         refill_coin,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [WIDTH-1:0]   remaining,
  output logic [STOCK_W-1:0] stock_q,
  output logic [STOCK_W-1:0] stock_d,
  output logic [STOCK_W-1:0] stock_n
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, DONE, FAULT} state_t;

  localparam logic [2:0] COIN_Q = 3'b100;
  localparam logic [2:0] COIN_D = 3'b010;
  localparam logic [2:0] COIN_N = 3'b001;

  localparam logic [WIDTH-1:0] VAL_Q = WIDTH'(25);
  localparam logic [WIDTH-1:0] VAL_D = WIDTH'(10);
  localparam logic [WIDTH-1:0] VAL_N = WIDTH'(5);

  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] STOCK_MAX  = STOCK_W'(MAX_STOCK);
  localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   remaining_q, remaining_d;
  logic               eject_valid_q, eject_valid_d;
  logic [2:0]         eject_coin_q, eject_coin_d;
  logic [STOCK_W-1:0] qtr_q, qtr_d;
  logic [STOCK_W-1:0] dime_q, dime_d;
  logic [STOCK_W-1:0] nick_q, nick_d;

  logic               ack_fire;
  logic [2:0]         inc_vec;
  logic [2:0]         dec_vec;
  logic [WIDTH-1:0]   coin_value;

  // Refill wins against saturation only when it is not cancelled by a same-coin eject.
  function automatic logic [STOCK_W-1:0] next_stock(input logic [STOCK_W-1:0] cur,
                                                    input logic inc, input logic dec);
    if (inc && !dec) begin
      return (cur < STOCK_MAX) ? cur + STOCK_ONE : cur;
    end else if (dec && !inc) begin
      return cur - STOCK_ONE;
    end else begin
      return cur;
    end
  endfunction

  // Handshake completion, refill decode (one-hot only) and value of the coin in flight.
  always_comb begin
    ack_fire = (state_q == EJECT) && eject_valid_q && eject_ack;
    dec_vec  = ack_fire ? eject_coin_q : 3'b000;
    inc_vec  = 3'b000;
    if (refill && ((refill_coin == COIN_Q) || (refill_coin == COIN_D) || (refill_coin == COIN_N))) begin
      inc_vec = refill_coin;
    end
    case (eject_coin_q)
      COIN_Q:  coin_value = VAL_Q;
      COIN_D:  coin_value = VAL_D;
      COIN_N:  coin_value = VAL_N;
      default: coin_value = '0;
    endcase
  end

  // Inventory next-state: refills and acked ejects applied independently per denomination.
  always_comb begin
    qtr_d  = next_stock(qtr_q,  inc_vec[2], dec_vec[2]);
    dime_d = next_stock(dime_q, inc_vec[1], dec_vec[1]);
    nick_d = next_stock(nick_q, inc_vec[0], dec_vec[0]);
  end

  // Payout FSM: greedy selection against registered stock, one coin per handshake.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    eject_valid_d = eject_valid_q;
    eject_coin_d  = eject_coin_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = balance;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q >= VAL_Q && qtr_q != '0) begin
          eject_coin_d = COIN_Q;
        end else if (remaining_q >= VAL_D && dime_q != '0) begin
          eject_coin_d = COIN_D;
        end else if (remaining_q >= VAL_N && nick_q != '0) begin
          eject_coin_d = COIN_N;
        end else begin
          eject_coin_d = 3'b000;
        end
        if (eject_coin_d != 3'b000) begin
          eject_valid_d = 1'b1;
          state_d       = EJECT;
        end else if (remaining_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = FAULT;
        end
      end
      EJECT: begin
        if (ack_fire) begin
          remaining_d   = remaining_q - coin_value;
          eject_valid_d = 1'b0;
          eject_coin_d  = 3'b000;
          state_d       = SELECT;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any payout without touching outputs' history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      eject_valid_q <= 1'b0;
      eject_coin_q  <= 3'b000;
      qtr_q         <= STOCK_INIT;
      dime_q        <= STOCK_INIT;
      nick_q        <= STOCK_INIT;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      eject_valid_q <= eject_valid_d;
      eject_coin_q  <= eject_coin_d;
      qtr_q         <= qtr_d;
      dime_q        <= dime_d;
      nick_q        <= nick_d;
    end
  end

  assign eject_valid = eject_valid_q;
  assign eject_coin  = eject_coin_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign fault       = (state_q == FAULT);
  assign remaining   = remaining_q;
  assign stock_q     = qtr_q;
  assign stock_d     = dime_q;
  assign stock_n     = nick_q;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Payout side of the vending datapath. It takes a change balance in cents and ejects it as a sequence of quarter, dime and nickel pulses to the coin hopper, one coin per valid/ack handshake. Coin selection is greedy and limited by on-board coin stock. The block tracks per-denomination inventory, accepts refills, and flags a shortfall when the balance cannot be paid exactly.

Parameters:
WIDTH, 8, width of balance/remaining datapath in cents
STOCK_W, 6, width of each per-coin inventory counter
INIT_STOCK, 10, inventory value loaded for every denomination at reset
MAX_STOCK, 63, saturation ceiling for refills (must be <= 2^STOCK_W-1)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  request payout of balance; sampled only in IDLE
balance  in  WIDTH  change owed in cents, captured on accepted start
eject_valid  out  1  coin eject request to hopper
eject_coin  out  3  one-hot {quarter,dime,nickel}; meaningful only while eject_valid
eject_ack  in  1  hopper has released the coin; completes handshake when eject_valid=1
refill  in  1  add one coin of refill_coin to inventory
refill_coin  in  3  one-hot denomination for refill; non-one-hot ignored
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse: full balance paid
fault  out  1  one-cycle pulse: payout stopped with nonzero remainder
remaining  out  WIDTH  cents still owed; holds after done/fault until next start
stock_q, stock_d, stock_n  out  STOCK_W  current inventory counts

Behaviour:
- Reset (sync, high): state=IDLE; eject_valid=0, eject_coin=0, done=0, fault=0, busy=0, remaining=0; all stocks=INIT_STOCK. Reset mid-payout aborts immediately; no done/fault is issued and the coin in flight is not decremented.
- States: IDLE, SELECT, EJECT, DONE, FAULT.
- IDLE: start=1 -> remaining<=balance, go SELECT. start in any other state is ignored.
- SELECT (1 cycle): greedy pick, in priority order: quarter if remaining>=25 and stock_q>0; else dime if remaining>=10 and stock_d>0; else nickel if remaining>=5 and stock_n>0. If a coin is picked, register eject_coin, set eject_valid=1, go EJECT. Else if remaining==0, go DONE. Else go FAULT.
- EJECT: eject_valid and eject_coin are held stable until eject_ack=1. On the ack cycle, remaining -= coin value, the matching stock decrements by 1, eject_valid<=0 and the state goes to SELECT. An ack when eject_valid=0 is ignored.
- Latency: start to first eject_valid is 2 cycles. With ack held at 1, each coin takes 2 cycles (EJECT+SELECT).
- DONE: done=1 for one cycle, return to IDLE. FAULT: fault=1 for one cycle, remaining keeps the unpaid amount, return to IDLE.
- Non-multiple-of-5 balances pay down greedily, then fault with remainder 1..4.
- Refill is accepted in any state. The matching stock increments, saturating at MAX_STOCK.
- Refill and ack on the same denomination in the same cycle: net stock change is 0. Refill on a different denomination than the ack: both apply.
- A refill landing during SELECT affects the next SELECT only; the current selection uses registered stock.
- Arithmetic: the subtraction never underflows, because a coin is only selected when remaining >= its value. All counters are unsigned.

Test Plan:
- Stocks 10/10/10, start with balance=40, ack tied 1 -> coins quarter, dime, nickel in order. done pulses at cycle 8 after start. remaining=0. Stocks end 9/9/9.
- stock_q forced to 0 via reset plus ejects, balance=30 -> three dime ejects, then done. stock_d drops by 3.
- balance=0 -> no eject_valid. done pulses 2 cycles after start. busy is high for exactly 2 cycles.
- balance=7 -> one nickel, then fault pulse with remaining=2. No done.
- balance=25, ack withheld 5 cycles -> eject_valid and eject_coin=100 stay stable throughout. Single decrement on ack. A start pulse issued during EJECT is ignored.
- Simultaneous refill_coin=100 and ack of a quarter: stock_q unchanged. Refill at stock 63: stays 63. Reset asserted during EJECT: next cycle eject_valid=0, busy=0, stocks=10.
